// File: rtl/clk_rate_gen.sv
// -----------------------------------------------------------------------------
// clk_rate_gen
//   Derives a slow CPU clock (clk_n) from the board clock clk. There are four
//   compile-time divide ratios, selected by rate_sel. The block supports:
//     - glitch-free rate switching (the new rate is taken only at a falling
//       edge of clk_n, or at any time while paused),
//     - run/pause control (a pause always completes the current low phase),
//     - single-step of exactly one full slow-clock period from pause.
//
//   Ports
//     clk       in   board clock, all logic on its rising edge
//     clr       in   asynchronous active-high reset
//     rate_sel  in   [1:0] requested rate index
//     run       in   1 = free-run, 0 = pause
//     step      in   single-step request, edge-detected internally
//     clk_n     out  divided clock (registered)
//     tick      out  one-clk pulse in the cycle clk_n goes 0->1
//     busy      out  high while a single step is in progress
//     cur_rate  out  [1:0] rate index currently in effect
//     cyc_cnt   out  [31:0] count of ticks (only with CLK_RATE_CYCLE_CNT_EN)
//
//   Optional feature macro: CLK_RATE_CYCLE_CNT_EN adds the cyc_cnt port.
// -----------------------------------------------------------------------------
module clk_rate_gen #(
  parameter int unsigned           CNT_W = 32,
  parameter logic [CNT_W-1:0]      DIV0  = CNT_W'(10000),
  parameter logic [CNT_W-1:0]      DIV1  = CNT_W'(100000),
  parameter logic [CNT_W-1:0]      DIV2  = CNT_W'(1000000),
  parameter logic [CNT_W-1:0]      DIV3  = CNT_W'(10000000)
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [1:0]  rate_sel,
  input  logic        run,
  input  logic        step,
  output logic        clk_n,
  output logic        tick,
  output logic        busy,
`ifdef CLK_RATE_CYCLE_CNT_EN
  output logic [1:0]  cur_rate,
  output logic [31:0] cyc_cnt
`else
  output logic [1:0]  cur_rate
`endif
);

  typedef enum logic [1:0] {
    S_RUN,
    S_PAUSE,
    S_STEP_HI,
    S_STEP_LO
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active_div;
  logic             step_q;
  logic             step_rise;
  logic             last;

  // Half-period lookup; a zero divide value would never terminate a phase,
  // so it is clamped to 1.
  function automatic logic [CNT_W-1:0] div_of(input logic [1:0] sel);
    logic [CNT_W-1:0] d;
    d = DIV0;
    case (sel)
      2'd0: d = DIV0;
      2'd1: d = DIV1;
      2'd2: d = DIV2;
      2'd3: d = DIV3;
    endcase
    return (d == '0) ? CNT_W'(1) : d;
  endfunction

  assign step_rise = step & ~step_q;
  assign last      = (cnt == active_div - CNT_W'(1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= S_RUN;
      cnt        <= '0;
      active_div <= div_of(2'd0);
      cur_rate   <= 2'd0;
      clk_n      <= 1'b0;
      tick       <= 1'b0;
      busy       <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      step_q <= step;
      tick   <= 1'b0;
      case (state)
        S_RUN: begin
          if (last) begin
            cnt <= '0;
            if (clk_n) begin
              // Falling toggle: the only point a new rate is accepted while
              // running, so both phases of a period always use one divide.
              clk_n      <= 1'b0;
              active_div <= div_of(rate_sel);
              cur_rate   <= rate_sel;
            end else if (run) begin
              clk_n <= 1'b1;
              tick  <= 1'b1;
            end else begin
              // Rise suppressed: low phase is complete, park here.
              state <= S_PAUSE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_PAUSE: begin
          cnt        <= '0;
          clk_n      <= 1'b0;
          active_div <= div_of(rate_sel);
          cur_rate   <= rate_sel;
          // run has priority over a simultaneous step edge.
          if (run) begin
            clk_n <= 1'b1;
            tick  <= 1'b1;
            state <= S_RUN;
          end else if (step_rise) begin
            clk_n <= 1'b1;
            tick  <= 1'b1;
            busy  <= 1'b1;
            state <= S_STEP_HI;
          end
        end

        S_STEP_HI: begin
          if (last) begin
            cnt        <= '0;
            clk_n      <= 1'b0;
            active_div <= div_of(rate_sel);
            cur_rate   <= rate_sel;
            state      <= S_STEP_LO;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_STEP_LO: begin
          if (last) begin
            cnt  <= '0;
            busy <= 1'b0;
            if (run) begin
              clk_n <= 1'b1;
              tick  <= 1'b1;
              state <= S_RUN;
            end else begin
              state <= S_PAUSE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= S_RUN;
      endcase
    end
  end

`ifdef CLK_RATE_CYCLE_CNT_EN
  // Counts tick pulses; wraps naturally at 32 bits.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cyc_cnt <= '0;
    end else if (tick) begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/clk_rate_gen.md
Name: clk_rate_gen

Overview:
- Parametrised clock-rate generator. Derives a slow CPU clock (clk_n) from the board clock clk, with four compile-time selectable divide ratios.
- Adds what the fixed-ratio divider lacks: glitch-free rate switching, run/pause control, and single-step of exactly one full slow-clock period.
- Sits between the board clock and the CPU/debug logic. tick is provided for logic that stays on clk.

Parameters:
- CNT_W, 32: width of the half-period counter and divide values.
- DIV0, 10000: half-period in clk cycles for rate_sel=0.
- DIV1, 100000: half-period for rate_sel=1.
- DIV2, 1000000: half-period for rate_sel=2.
- DIV3, 10000000: half-period for rate_sel=3.

Ports:
- clk  in  1  board clock; all logic on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- rate_sel  in  2  requested rate index.
- run  in  1  1 = free-run, 0 = pause.
- step  in  1  single-step request; acted on at its rising edge (edge-detected internally).
- clk_n  out  1  divided clock, registered.
- tick  out  1  one-cycle pulse, asserted in the same cycle clk_n registers 0->1.
- busy  out  1  high while a single step is in progress.
- cur_rate  out  2  rate index currently in effect.

Behaviour:
- Reset values (asynchronous on clr=1): clk_n=0, tick=0, busy=0, cur_rate=0, counter=0, active divide=DIV0, step edge-detector register=0, state RUN.
- Divide values of 0 are treated as 1.
- Half-period counting:
  - The counter increments each clk. When it reaches active_div-1, the next edge toggles clk_n and clears the counter.
  - Each phase is therefore exactly active_div clk cycles, giving 50% duty.
  - After clr release, the first rising toggle occurs on the DIV0-th clk edge.
- Rate switching:
  - rate_sel is sampled only on a falling toggle (clk_n 1->0), and continuously while in PAUSE.
  - active_div and cur_rate update on that edge, so no partial or short phase is ever produced.
- FSM states:
  - RUN: free-running.
  - PAUSE: clk_n held 0, counter held 0, tick=0.
  - STEP_HI, STEP_LO: one full period; busy=1.
- RUN -> PAUSE: if run=0 at the point where a rising toggle would occur, that rise is suppressed. The full low phase always completes before pausing.
- PAUSE -> RUN: when run=1 is sampled, clk_n rises on the next edge with tick=1 and counter=0.
- PAUSE -> STEP_HI: on a step rising edge, clk_n rises on the next edge with tick=1.
- STEP_HI -> STEP_LO: after active_div cycles, clk_n falls.
- STEP_LO exit: after active_div cycles, go to PAUSE if run=0, or to RUN if run=1 (immediate rise, as for PAUSE -> RUN).
- Step requests in RUN, STEP_HI or STEP_LO are ignored. They are not queued.
- If run=1 and a step rising edge are seen in the same PAUSE cycle, run wins.
- clr mid-operation (any state, any phase) forces all reset values immediately, without waiting for a clk edge.

Optional Feature:
- Macro: CLK_RATE_CYCLE_CNT_EN.
- Defined:
  - Extra output port cyc_cnt, 32 bits, reset to 0.
  - Increments by 1 on every tick, in both RUN and step modes.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: port absent; no counter logic.

Test Plan:
- Bench parameters: DIV0=2, DIV1=3, DIV2=5, DIV3=8.
- Free-run: clr pulse, then run=1, rate_sel=0 -> clk_n first rises 2 cycles after release, period 4 cycles, high 2 / low 2, tick once every 4 cycles, cur_rate=0.
- Rate switch: rate_sel 0->2 during a high phase -> that high phase stays 2 cycles; cur_rate becomes 2 at the falling edge; following phases are 5 high / 5 low with no short phase.
- Pause: run=0 during a high phase -> high finishes (2 cycles), low finishes (2 cycles), then clk_n stays 0 and tick stays 0 for 20 cycles; busy=0.
- Single step: paused, rate_sel=1, step pulse -> busy=1, exactly one tick, clk_n high 3 then low 3, then back to PAUSE with busy=0. A second step pulse while busy is ignored (total ticks = 1).
- Async reset: assert clr between clk edges during STEP_HI -> clk_n=0, busy=0, tick=0, cur_rate=0 immediately. After release with run=0, clk_n stays 0.
- Macro build with CLK_RATE_CYCLE_CNT_EN: run 10 periods at rate 0 -> cyc_cnt=10. Then clr -> cyc_cnt=0.
